// File: rtl/mem_test_pkg.sv
// Shared constants for the dual-port RAM self-test engine: pattern modes,
// FSM state encoding and the supported read-latency range.
package mem_test_pkg;

    localparam logic [1:0] MODE_ADDR  = 2'b00;
    localparam logic [1:0] MODE_CHECK = 2'b01;
    localparam logic [1:0] MODE_WALK  = 2'b10;
    localparam logic [1:0] MODE_INV   = 2'b11;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_VERIFY,
        S_DRAIN,
        S_DONE
    } state_e;

endpackage

// File: rtl/mem_test_pattern_gen.sv
// Combinational test pattern for a given address and mode.
module mem_test_pattern_gen
    import mem_test_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [1:0]            mode,
    output logic [DATA_WIDTH-1:0] pat
);

    logic [DATA_WIDTH-1:0] base;

    always_comb begin
        // Address zero-extended or truncated to the word width.
        for (int i = 0; i < DATA_WIDTH; i++) begin
            base[i] = (i < ADDR_WIDTH) ? addr[i % ADDR_WIDTH] : 1'b0;
        end
        pat = '0;
        case (mode)
            MODE_ADDR: pat = base;
            MODE_CHECK: begin
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    pat[i] = (i % 2 == 0) ? addr[0] : ~addr[0];
                end
            end
            MODE_WALK: pat = DATA_WIDTH'(1) << (32'(addr) % DATA_WIDTH);
            default:   pat = ~base;
        endcase
    end

endmodule

// File: rtl/mem_bist_dualport.sv
// Dual-port RAM self-test: writes a pattern through port A, reads every word
// back on both ports and counts mismatches.
module mem_bist_dualport
    import mem_test_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 10,
    parameter int RD_LATENCY    = 1,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               mode,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [ADDR_WIDTH-1:0]    first_err_addr,
    output logic                     err_valid,
    output logic                     we_a,
    output logic [ADDR_WIDTH-1:0]    addr_a,
    output logic [DATA_WIDTH-1:0]    wdata_a,
    output logic [ADDR_WIDTH-1:0]    addr_b,
    input  logic [DATA_WIDTH-1:0]    rdata_a,
    input  logic [DATA_WIDTH-1:0]    rdata_b
);

    localparam int RL = (RD_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
                        (RD_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : RD_LATENCY;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_e                        state_q, state_d;
    logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
    logic [1:0]                    mode_q, mode_d;
    logic [1:0]                    drain_q, drain_d;
    logic [RL-1:0]                 pvld_q, pvld_d;
    logic [RL-1:0][ADDR_WIDTH-1:0] padr_q, padr_d;
    logic [ERR_CNT_WIDTH-1:0]      err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0]         ferr_q, ferr_d;
    logic                          errv_q, errv_d;
    logic                          pass_q, pass_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;

    logic [DATA_WIDTH-1:0]         pat_wr, pat_cmp;
    logic [1:0]                    miss;
    logic [ERR_CNT_WIDTH:0]        sum;

    mem_test_pattern_gen #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_pat_wr (
        .addr (addr_q),
        .mode (mode_q),
        .pat  (pat_wr)
    );

    mem_test_pattern_gen #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_pat_cmp (
        .addr (padr_q[RL-1]),
        .mode (mode_q),
        .pat  (pat_cmp)
    );

    assign miss = 2'(rdata_a != pat_cmp) + 2'(rdata_b != pat_cmp);
    assign sum  = {1'b0, err_cnt_q} + (ERR_CNT_WIDTH+1)'(miss);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        mode_d    = mode_q;
        drain_d   = drain_q;
        err_cnt_d = err_cnt_q;
        ferr_d    = ferr_q;
        errv_d    = errv_q;
        pass_d    = pass_q;

        // Read tags travel alongside the RAM latency so the head lines up with rdata.
        pvld_d[0] = (state_q == S_VERIFY);
        padr_d[0] = addr_q;
        for (int i = 1; i < RL; i++) begin
            pvld_d[i] = pvld_q[i-1];
            padr_d[i] = padr_q[i-1];
        end

        if (pvld_q[RL-1] && (miss != 2'd0)) begin
            err_cnt_d = sum[ERR_CNT_WIDTH] ? '1 : sum[ERR_CNT_WIDTH-1:0];
            if (!errv_q) begin
                errv_d = 1'b1;
                ferr_d = padr_q[RL-1];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d    = mode;
                    err_cnt_d = '0;
                    errv_d    = 1'b0;
                    ferr_d    = '0;
                    pass_d    = 1'b0;
                    addr_d    = '0;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = S_VERIFY;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            S_VERIFY: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    drain_d = 2'd0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                // The last DRAIN cycle carries the final compare, so pass sees it.
                if (drain_q == 2'(RL-1)) begin
                    pass_d  = (err_cnt_d == '0);
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_WRITE) || (state_d == S_VERIFY) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            mode_q    <= 2'd0;
            drain_q   <= 2'd0;
            pvld_q    <= '0;
            padr_q    <= '0;
            err_cnt_q <= '0;
            ferr_q    <= '0;
            errv_q    <= 1'b0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            mode_q    <= mode_d;
            drain_q   <= drain_d;
            pvld_q    <= pvld_d;
            padr_q    <= padr_d;
            err_cnt_q <= err_cnt_d;
            ferr_q    <= ferr_d;
            errv_q    <= errv_d;
            pass_q    <= pass_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_cnt_q;
    assign first_err_addr = ferr_q;
    assign err_valid      = errv_q;
    assign we_a           = (state_q == S_WRITE);
    assign addr_a         = ((state_q == S_WRITE) || (state_q == S_VERIFY)) ? addr_q : '0;
    assign addr_b         = (state_q == S_VERIFY) ? addr_q : '0;
    assign wdata_a        = (state_q == S_WRITE) ? pat_wr : '0;

endmodule

// File: tb/tb_mem_bist_dualport.sv
// Directed bench: four engine configurations, each beside its own behavioural RAM.
module tb_mem_bist_dualport;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rst, st;
    logic [1:0] md;
    logic       flt0;
    int vec = 0;
    int miss = 0;

    // u0: AW=4, RL=1, 16-bit counter, optional stuck bit at addr 5
    logic        we0, busy0, done0, pass0, ev0;
    logic [3:0]  aa0, ab0, fea0;
    logic [15:0] wd0, ra0, rb0, ec0;
    logic [15:0] mem0 [16];
    // u1: AW=5
    logic        we1, busy1, done1, pass1, ev1;
    logic [4:0]  aa1, ab1, fea1;
    logic [15:0] wd1, ra1, rb1, ec1;
    logic [15:0] mem1 [32];
    logic [15:0] cap17 = '0, cap3 = '0;
    // u2: 2-bit counter, every read corrupted
    logic        we2, busy2, done2, pass2, ev2;
    logic [3:0]  aa2, ab2, fea2;
    logic [15:0] wd2, ra2, rb2;
    logic [1:0]  ec2;
    logic [15:0] mem2 [16];
    // u3: RL=2
    logic        we3, busy3, done3, pass3, ev3;
    logic [3:0]  aa3, ab3, fea3;
    logic [15:0] wd3, ra3, rb3, ra3_p, rb3_p, ec3;
    logic [15:0] mem3 [16];

    logic [3:0] done_v;
    assign done_v = {done3, done2, done1, done0};

    mem_bist_dualport #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_LATENCY(1), .ERR_CNT_WIDTH(16)) u0 (
        .clock(clk), .reset(rst[0]), .start(st[0]), .mode(md), .busy(busy0), .done(done0),
        .pass(pass0), .err_count(ec0), .first_err_addr(fea0), .err_valid(ev0), .we_a(we0),
        .addr_a(aa0), .wdata_a(wd0), .addr_b(ab0), .rdata_a(ra0), .rdata_b(rb0));
    mem_bist_dualport #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .RD_LATENCY(1), .ERR_CNT_WIDTH(16)) u1 (
        .clock(clk), .reset(rst[1]), .start(st[1]), .mode(md), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(ec1), .first_err_addr(fea1), .err_valid(ev1), .we_a(we1),
        .addr_a(aa1), .wdata_a(wd1), .addr_b(ab1), .rdata_a(ra1), .rdata_b(rb1));
    mem_bist_dualport #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_LATENCY(1), .ERR_CNT_WIDTH(2)) u2 (
        .clock(clk), .reset(rst[2]), .start(st[2]), .mode(md), .busy(busy2), .done(done2),
        .pass(pass2), .err_count(ec2), .first_err_addr(fea2), .err_valid(ev2), .we_a(we2),
        .addr_a(aa2), .wdata_a(wd2), .addr_b(ab2), .rdata_a(ra2), .rdata_b(rb2));
    mem_bist_dualport #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_LATENCY(2), .ERR_CNT_WIDTH(16)) u3 (
        .clock(clk), .reset(rst[3]), .start(st[3]), .mode(md), .busy(busy3), .done(done3),
        .pass(pass3), .err_count(ec3), .first_err_addr(fea3), .err_valid(ev3), .we_a(we3),
        .addr_a(aa3), .wdata_a(wd3), .addr_b(ab3), .rdata_a(ra3), .rdata_b(rb3));

    always @(posedge clk) begin
        if (we0) mem0[aa0] <= wd0;
        ra0 <= (flt0 && aa0 == 4'd5) ? (mem0[aa0] & 16'hFFFE) : mem0[aa0];
        rb0 <= (flt0 && ab0 == 4'd5) ? (mem0[ab0] & 16'hFFFE) : mem0[ab0];
        if (we1) mem1[aa1] <= wd1;
        ra1 <= mem1[aa1];
        rb1 <= mem1[ab1];
        if (we1 && aa1 == 5'd17) cap17 <= wd1;
        if (we1 && aa1 == 5'd3) cap3 <= wd1;
        if (we2) mem2[aa2] <= wd2;
        ra2 <= mem2[aa2] ^ 16'h0001;
        rb2 <= mem2[ab2] ^ 16'h0001;
        if (we3) mem3[aa3] <= wd3;
        ra3_p <= mem3[aa3];
        rb3_p <= mem3[ab3];
        ra3 <= ra3_p;
        rb3 <= rb3_p;
    end

    // k = edges from the start-sampling edge to the edge that opened the done cycle
    task automatic run(input int idx, input logic [1:0] m, output int k);
        @(negedge clk);
        md = m;
        st[idx] = 1'b1;
        @(negedge clk);
        st[idx] = 1'b0;
        md = ~m;
        k = 0;
        while (!done_v[idx] && k < 200) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        rst = '1; st = '0; md = 2'd0; flt0 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        if ({busy0, done0, pass0, ev0, we0} !== 5'b0) begin $display("FAIL rst_flags got %b want 00000", {busy0, done0, pass0, ev0, we0}); miss++; end vec++;
        if (ec0 !== 16'd0) begin $display("FAIL rst_err_count got %0h want 0", ec0); miss++; end vec++;
        if (fea0 !== 4'd0) begin $display("FAIL rst_first_err got %0h want 0", fea0); miss++; end vec++;
        if ({aa0, ab0} !== 8'd0) begin $display("FAIL rst_addr got %0h want 0", {aa0, ab0}); miss++; end vec++;
        if (wd0 !== 16'd0) begin $display("FAIL rst_wdata got %0h want 0", wd0); miss++; end vec++;
        if ({busy1, busy2, busy3, done1, done2, done3} !== 6'b0) begin $display("FAIL rst_others got %b want 0", {busy1, busy2, busy3, done1, done2, done3}); miss++; end vec++;
        rst = '0;
    endtask

    task automatic test_basic();
        int k;
        run(0, 2'b00, k);
        if (k !== 33) begin $display("FAIL basic_latency got %0d want 33", k); miss++; end vec++;
        if (pass0 !== 1'b1) begin $display("FAIL basic_pass got %b want 1", pass0); miss++; end vec++;
        if (ec0 !== 16'd0) begin $display("FAIL basic_err_count got %0h want 0", ec0); miss++; end vec++;
        if (ev0 !== 1'b0) begin $display("FAIL basic_err_valid got %b want 0", ev0); miss++; end vec++;
        if (busy0 !== 1'b0) begin $display("FAIL basic_busy_in_done got %b want 0", busy0); miss++; end vec++;
        @(negedge clk);
        if (done0 !== 1'b0) begin $display("FAIL basic_done_width got %b want 0", done0); miss++; end vec++;
        if (pass0 !== 1'b1) begin $display("FAIL basic_pass_held got %b want 1", pass0); miss++; end vec++;
    endtask

    task automatic test_reset_mid();
        int k;
        @(negedge clk);
        md = 2'b00;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (7) @(negedge clk);
        if ({we0, aa0} !== 5'b1_0111) begin $display("FAIL mid_write_addr got %b want 10111", {we0, aa0}); miss++; end vec++;
        if (wd0 !== 16'h0007) begin $display("FAIL mid_write_data got %0h want 7", wd0); miss++; end vec++;
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        if ({busy0, we0} !== 2'b00) begin $display("FAIL mid_reset_busy_we got %b want 00", {busy0, we0}); miss++; end vec++;
        if (ec0 !== 16'd0 || aa0 !== 4'd0) begin $display("FAIL mid_reset_cnt_addr got %0h/%0h want 0/0", ec0, aa0); miss++; end vec++;
        run(0, 2'b00, k);
        if (k !== 33 || pass0 !== 1'b1) begin $display("FAIL mid_restart got k=%0d pass=%b want 33/1", k, pass0); miss++; end vec++;
    endtask

    task automatic test_fault();
        int k;
        flt0 = 1'b1;
        run(0, 2'b01, k);
        flt0 = 1'b0;
        if (k !== 33) begin $display("FAIL fault_latency got %0d want 33", k); miss++; end vec++;
        if (ec0 !== 16'd2) begin $display("FAIL fault_err_count got %0d want 2", ec0); miss++; end vec++;
        if (fea0 !== 4'd5) begin $display("FAIL fault_first_addr got %0d want 5", fea0); miss++; end vec++;
        if ({ev0, pass0} !== 2'b10) begin $display("FAIL fault_valid_pass got %b want 10", {ev0, pass0}); miss++; end vec++;
    endtask

    task automatic test_walk();
        int k;
        run(1, 2'b10, k);
        if (k !== 65) begin $display("FAIL walk_latency got %0d want 65", k); miss++; end vec++;
        if (cap17 !== 16'h0002) begin $display("FAIL walk_addr17 got %0h want 0002", cap17); miss++; end vec++;
        if (cap3 !== 16'h0008) begin $display("FAIL walk_addr3 got %0h want 0008", cap3); miss++; end vec++;
        if (pass1 !== 1'b1 || ec1 !== 16'd0) begin $display("FAIL walk_pass got %b/%0d want 1/0", pass1, ec1); miss++; end vec++;
    endtask

    task automatic test_saturate();
        int dcnt = 0;
        int kd = -1;
        @(negedge clk);
        md = 2'b00;
        st[2] = 1'b1;
        @(negedge clk);
        st[2] = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (done2) begin dcnt++; kd = k; end
            // also pulse start during the done cycle itself
            st[2] = (k == 10) || done2;
            @(negedge clk);
        end
        st[2] = 1'b0;
        if (dcnt !== 1) begin $display("FAIL sat_done_pulses got %0d want 1", dcnt); miss++; end vec++;
        if (kd !== 33) begin $display("FAIL sat_latency got %0d want 33", kd); miss++; end vec++;
        if (ec2 !== 2'd3) begin $display("FAIL sat_err_count got %0d want 3", ec2); miss++; end vec++;
        if (fea2 !== 4'd0 || ev2 !== 1'b1) begin $display("FAIL sat_first_err got %0d/%b want 0/1", fea2, ev2); miss++; end vec++;
        if ({pass2, busy2} !== 2'b00) begin $display("FAIL sat_pass_busy got %b want 00", {pass2, busy2}); miss++; end vec++;
    endtask

    task automatic test_rl2();
        int k;
        run(3, 2'b11, k);
        if (k !== 34) begin $display("FAIL rl2_latency got %0d want 34", k); miss++; end vec++;
        if (pass3 !== 1'b1 || ec3 !== 16'd0) begin $display("FAIL rl2_pass got %b/%0d want 1/0", pass3, ec3); miss++; end vec++;
        if (ev3 !== 1'b0) begin $display("FAIL rl2_err_valid got %b want 0", ev3); miss++; end vec++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid();
        test_fault();
        test_walk();
        test_saturate();
        test_rl2();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
